// File: rtl/key_scan.sv
// Two-button front end: synchronises raw keys, debounces them on a slow sample
// tick, and emits press/release pulses with auto-repeat on the add key.
module key_scan #(
  parameter int TICK_DIV       = 1024,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int LONG_TICKS     = 64,
  parameter int REPEAT_TICKS   = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic key_mode,
  input  logic key_add,
  output logic key_mode_down,
  output logic key_add_down,
  output logic key_add_negedge,
  output logic key_mode_level,
  output logic key_add_level,
  output logic key_add_long
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int LW = $clog2(LONG_TICKS + 1);
  localparam int RW = $clog2(REPEAT_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_TICKS - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_TICKS - 1);
  localparam bit            DB_ONE    = (DEBOUNCE_TICKS == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_DB,
    S_HELD,
    S_REL_DB,
    S_REPEAT
  } state_e;

  logic [1:0]    mode_sync_q, add_sync_q;
  logic          mode_sample, add_sample;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;

  state_e        mode_state_q, add_state_q;
  logic [DW-1:0] mode_db_q, add_db_q;
  logic [LW-1:0] add_long_q;
  logic [RW-1:0] add_rep_q;
  logic          mode_armed_q, add_armed_q;

  assign mode_sample = mode_sync_q[1];
  assign add_sample  = add_sync_q[1];

  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_sync_q <= '0;
      add_sync_q  <= '0;
      tick_cnt_q  <= '0;
    end else begin
      mode_sync_q <= {mode_sync_q[0], key_mode};
      add_sync_q  <= {add_sync_q[0], key_add};
      tick_cnt_q  <= tick_cnt_d;
    end
  end

  // A key must be seen released on a tick after reset before a press is
  // accepted, so a key held through reset never produces a pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_state_q   <= S_IDLE;
      mode_db_q      <= '0;
      mode_armed_q   <= 1'b0;
      key_mode_down  <= 1'b0;
      key_mode_level <= 1'b0;
    end else begin
      key_mode_down <= 1'b0;
      if (tick && !mode_sample) mode_armed_q <= 1'b1;
      if (tick) begin
        case (mode_state_q)
          S_IDLE: begin
            if (mode_sample && mode_armed_q) begin
              if (DB_ONE) begin
                mode_state_q   <= S_HELD;
                key_mode_down  <= 1'b1;
                key_mode_level <= 1'b1;
              end else begin
                mode_state_q <= S_PRESS_DB;
                mode_db_q    <= DW'(1);
              end
            end
          end
          S_PRESS_DB: begin
            if (!mode_sample) begin
              mode_state_q <= S_IDLE;
              mode_db_q    <= '0;
            end else if (mode_db_q == DB_LAST) begin
              mode_state_q   <= S_HELD;
              mode_db_q      <= '0;
              key_mode_down  <= 1'b1;
              key_mode_level <= 1'b1;
            end else begin
              mode_db_q <= mode_db_q + 1'b1;
            end
          end
          S_HELD: begin
            if (!mode_sample) begin
              if (DB_ONE) begin
                mode_state_q   <= S_IDLE;
                key_mode_level <= 1'b0;
              end else begin
                mode_state_q <= S_REL_DB;
                mode_db_q    <= DW'(1);
              end
            end
          end
          S_REL_DB: begin
            if (mode_sample) begin
              mode_state_q <= S_HELD;
              mode_db_q    <= '0;
            end else if (mode_db_q == DB_LAST) begin
              mode_state_q   <= S_IDLE;
              mode_db_q      <= '0;
              key_mode_level <= 1'b0;
            end else begin
              mode_db_q <= mode_db_q + 1'b1;
            end
          end
          default: begin
            mode_state_q <= S_IDLE;
            mode_db_q    <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      add_state_q     <= S_IDLE;
      add_db_q        <= '0;
      add_long_q      <= '0;
      add_rep_q       <= '0;
      add_armed_q     <= 1'b0;
      key_add_down    <= 1'b0;
      key_add_negedge <= 1'b0;
      key_add_level   <= 1'b0;
      key_add_long    <= 1'b0;
    end else begin
      key_add_down    <= 1'b0;
      key_add_negedge <= 1'b0;
      if (tick && !add_sample) add_armed_q <= 1'b1;
      if (tick) begin
        case (add_state_q)
          S_IDLE: begin
            if (add_sample && add_armed_q) begin
              if (DB_ONE) begin
                add_state_q   <= S_HELD;
                add_long_q    <= '0;
                key_add_down  <= 1'b1;
                key_add_level <= 1'b1;
              end else begin
                add_state_q <= S_PRESS_DB;
                add_db_q    <= DW'(1);
              end
            end
          end
          S_PRESS_DB: begin
            if (!add_sample) begin
              add_state_q <= S_IDLE;
              add_db_q    <= '0;
            end else if (add_db_q == DB_LAST) begin
              add_state_q   <= S_HELD;
              add_db_q      <= '0;
              add_long_q    <= '0;
              key_add_down  <= 1'b1;
              key_add_level <= 1'b1;
            end else begin
              add_db_q <= add_db_q + 1'b1;
            end
          end
          S_HELD, S_REPEAT: begin
            if (!add_sample) begin
              add_rep_q <= '0;
              if (DB_ONE) begin
                add_state_q     <= S_IDLE;
                key_add_level   <= 1'b0;
                key_add_negedge <= 1'b1;
                key_add_long    <= 1'b0;
              end else begin
                // key_add_long is left as is so it stays high through a release from REPEAT.
                add_state_q <= S_REL_DB;
                add_db_q    <= DW'(1);
              end
            end else if (add_state_q == S_HELD) begin
              if (add_long_q == LONG_LAST) begin
                add_state_q  <= S_REPEAT;
                add_long_q   <= '0;
                add_rep_q    <= '0;
                key_add_down <= 1'b1;
                key_add_long <= 1'b1;
              end else begin
                add_long_q <= add_long_q + 1'b1;
              end
            end else if (add_rep_q == REP_LAST) begin
              add_rep_q    <= '0;
              key_add_down <= 1'b1;
            end else begin
              add_rep_q <= add_rep_q + 1'b1;
            end
          end
          S_REL_DB: begin
            if (add_sample) begin
              add_state_q  <= S_HELD;
              add_db_q     <= '0;
              add_long_q   <= '0;
              key_add_long <= 1'b0;
            end else if (add_db_q == DB_LAST) begin
              add_state_q     <= S_IDLE;
              add_db_q        <= '0;
              add_long_q      <= '0;
              key_add_level   <= 1'b0;
              key_add_negedge <= 1'b1;
              key_add_long    <= 1'b0;
            end else begin
              add_db_q <= add_db_q + 1'b1;
            end
          end
          default: begin
            add_state_q <= S_IDLE;
            add_db_q    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan with a fast tick (4 clocks) and short debounce,
// long-press and repeat intervals.
`timescale 1ns/1ps
module tb_key_scan;

  localparam int TICK_DIV       = 4;
  localparam int DEBOUNCE_TICKS = 3;
  localparam int LONG_TICKS     = 8;
  localparam int REPEAT_TICKS   = 2;

  logic clock    = 1'b0;
  logic reset    = 1'b1;
  logic key_mode = 1'b0;
  logic key_add  = 1'b0;
  logic key_mode_down, key_add_down, key_add_negedge;
  logic key_mode_level, key_add_level, key_add_long;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  key_scan #(
    .TICK_DIV      (TICK_DIV),
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
    .LONG_TICKS    (LONG_TICKS),
    .REPEAT_TICKS  (REPEAT_TICKS)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .key_mode       (key_mode),
    .key_add        (key_add),
    .key_mode_down  (key_mode_down),
    .key_add_down   (key_add_down),
    .key_add_negedge(key_add_negedge),
    .key_mode_level (key_mode_level),
    .key_add_level  (key_add_level),
    .key_add_long   (key_add_long)
  );

  // Event monitor, sampled on the falling edge away from the active edge.
  int   cyc         = 0;
  int   mode_cnt    = 0;
  int   add_cnt     = 0;
  int   neg_cnt     = 0;
  int   add_lvl_cyc = 0;
  int   wide_cnt    = 0;
  int   neg_lvl_bad = 0;
  int   mode_last   = -1;
  int   mode_lvl_at = 0;
  int   add_cyc_q[$];
  int   add_long_q[$];
  logic prev_mode   = 1'b0;
  logic prev_add    = 1'b0;
  logic prev_neg    = 1'b0;

  always @(negedge clock) begin
    cyc++;
    if (key_mode_down) begin
      mode_cnt++;
      mode_last   = cyc;
      mode_lvl_at = int'(key_mode_level);
    end
    if (key_add_down) begin
      add_cnt++;
      add_cyc_q.push_back(cyc);
      add_long_q.push_back(int'(key_add_long));
    end
    if (key_add_negedge) begin
      neg_cnt++;
      if (key_add_level) neg_lvl_bad++;
    end
    if (key_add_level) add_lvl_cyc++;
    if ((key_mode_down && prev_mode) || (key_add_down && prev_add) ||
        (key_add_negedge && prev_neg)) wide_cnt++;
    prev_mode = key_mode_down;
    prev_add  = key_add_down;
    prev_neg  = key_add_negedge;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  function automatic int outs();
    return int'({key_mode_down, key_add_down, key_add_negedge,
                 key_mode_level, key_add_level, key_add_long});
  endfunction

  function automatic int cyc_at(input int i);
    return (i < add_cyc_q.size()) ? add_cyc_q[i] : -1000;
  endfunction

  function automatic int long_at(input int i);
    return (i < add_long_q.size()) ? add_long_q[i] : -1;
  endfunction

  int m0, c0, w0, d0, a0, n0, l0, i0, a1, n1, m2, a2, a3, l3, a4;

  initial begin
    #1 reset = 1'b0;
    wait_clk(3);
    check("reset_outputs", outs(), 0);
    reset = 1'b1;
    wait_clk(12);

    // Clean mode press: one pulse 12..15 falling edges after the press.
    m0 = mode_cnt; w0 = wide_cnt; c0 = cyc;
    key_mode = 1'b1;
    wait_clk(40);
    check("mode_one_pulse", mode_cnt - m0, 1);
    d0 = mode_last - c0;
    check("mode_latency_12_15", int'(d0 >= 12 && d0 <= 15), 1);
    check("mode_level_at_pulse", mode_lvl_at, 1);
    check("mode_pulse_width", wide_cnt - w0, 0);
    check("mode_level_held", int'(key_mode_level), 1);
    key_mode = 1'b0;
    wait_clk(30);
    check("mode_level_released", int'(key_mode_level), 0);
    check("mode_no_release_pulse", mode_cnt - m0, 1);

    // Add key bouncing every 3 clocks never holds for 3 consecutive ticks.
    a0 = add_cnt; n0 = neg_cnt; l0 = add_lvl_cyc;
    for (int i = 0; i < 10; i++) begin
      key_add = (i % 2 == 0);
      wait_clk(3);
    end
    key_add = 1'b0;
    wait_clk(30);
    check("bounce_no_down", add_cnt - a0, 0);
    check("bounce_no_negedge", neg_cnt - n0, 0);
    check("bounce_level_low", add_lvl_cyc - l0, 0);

    // Long hold: gap of 8 ticks to the first repeat, then every 2 ticks.
    i0 = add_cyc_q.size();
    key_add = 1'b1;
    wait_clk(80);
    check("rpt_pulses_ge4", int'(add_cyc_q.size() - i0 >= 4), 1);
    check("rpt_gap_long", cyc_at(i0 + 1) - cyc_at(i0), 32);
    check("rpt_gap_rep1", cyc_at(i0 + 2) - cyc_at(i0 + 1), 8);
    check("rpt_gap_rep2", cyc_at(i0 + 3) - cyc_at(i0 + 2), 8);
    check("rpt_long_first", long_at(i0), 0);
    check("rpt_long_second", long_at(i0 + 1), 1);
    check("rpt_long_held", int'(key_add_long), 1);

    // Release with a one-tick bounce back to pressed.
    key_add = 1'b0;
    wait_clk(3);
    a1 = add_cnt; n1 = neg_cnt;
    wait_clk(1);
    key_add = 1'b1;
    wait_clk(4);
    key_add = 1'b0;
    wait_clk(40);
    check("rel_no_extra_down", add_cnt - a1, 0);
    check("rel_one_negedge", neg_cnt - n1, 1);
    check("rel_long_cleared", int'(key_add_long), 0);
    check("rel_level_low", int'(key_add_level), 0);

    // Simultaneous press of both keys.
    m2 = mode_cnt; a2 = add_cnt;
    key_mode = 1'b1;
    key_add  = 1'b1;
    wait_clk(20);
    key_mode = 1'b0;
    key_add  = 1'b0;
    wait_clk(40);
    check("both_mode_pulse", mode_cnt - m2, 1);
    check("both_add_pulse", add_cnt - a2, 1);
    check("both_same_cycle", mode_last - cyc_at(add_cyc_q.size() - 1), 0);

    // Reset while in auto-repeat, then release reset with the key still held.
    key_add = 1'b1;
    wait_clk(60);
    check("pre_reset_repeat", int'(key_add_long), 1);
    reset = 1'b0;
    #1;
    check("async_reset_outputs", outs(), 0);
    wait_clk(3);
    reset = 1'b1;
    a3 = add_cnt; l3 = add_lvl_cyc;
    wait_clk(60);
    check("held_thru_reset_no_down", add_cnt - a3, 0);
    check("held_thru_reset_level", add_lvl_cyc - l3, 0);
    key_add = 1'b0;
    wait_clk(20);
    a4 = add_cnt;
    key_add = 1'b1;
    wait_clk(30);
    check("repress_after_reset", add_cnt - a4, 1);
    key_add = 1'b0;
    wait_clk(40);

    check("pulse_widths", wide_cnt, 0);
    check("negedge_level_low", neg_lvl_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_scan.md
KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1024: clock cycles per sample tick (>=2).
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 4: consecutive stable ticks needed to accept a level change (>=1).
REQ-003 SHALL have parameter LONG_TICKS, default 64: held ticks before the add key starts auto-repeat (>DEBOUNCE_TICKS).
REQ-004 SHALL have parameter REPEAT_TICKS, default 16: ticks between auto-repeat pulses (>=1).
REQ-005 SHALL have ports: clock  in  1  system clock; reset is asynchronous, active-low.
REQ-006 SHALL have ports: reset  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: key_mode  in  1  raw mode button, 1=pressed, asynchronous to clock.
REQ-008 SHALL have ports: key_add  in  1  raw add button, 1=pressed, asynchronous to clock.
REQ-009 SHALL have ports: key_mode_down  out  1  one-clock pulse on accepted mode press.
REQ-010 SHALL have ports: key_add_down  out  1  one-clock pulse on accepted add press and on each auto-repeat.
REQ-011 SHALL have ports: key_add_negedge  out  1  one-clock pulse on accepted add release.
REQ-012 SHALL have ports: key_mode_level, key_add_level  out  1 each  debounced level, 1=pressed.
REQ-013 SHALL have ports: key_add_long  out  1  high while the add key is in auto-repeat.

Function
REQ-014 Each raw key SHALL pass through a 2-flop synchronizer; only the second-flop value ("sample") is used.
REQ-015 A free-running tick counter SHALL count 0..TICK_DIV-1 and wrap; tick = 1 for the single cycle where count==TICK_DIV-1.
REQ-016 Each key SHALL have an FSM with states IDLE, PRESS_DB, HELD, REL_DB; the add key SHALL also have REPEAT.
REQ-017 In IDLE, on a tick with sample=1: go to PRESS_DB with debounce count=1; if DEBOUNCE_TICKS==1, go directly to HELD.
REQ-018 In PRESS_DB, on a tick with sample=1: increment the count; when it reaches DEBOUNCE_TICKS, go to HELD. On a tick with sample=0: return to IDLE with no pulse.
REQ-019 On entry to HELD from PRESS_DB, the key's down pulse SHALL be high for exactly the first clock in HELD; the level output SHALL be 1 from that same clock.
REQ-020 In HELD or REPEAT, on a tick with sample=0: go to REL_DB, count=1. REL_DB mirrors PRESS_DB: DEBOUNCE_TICKS released ticks go to IDLE; a pressed tick returns to HELD with the long counter cleared and no pulse.
REQ-021 On REL_DB->IDLE, the level SHALL drop to 0 on the first clock in IDLE; for the add key, key_add_negedge SHALL pulse on that clock.
REQ-022 Add key in HELD: count ticks with sample=1; on reaching LONG_TICKS, go to REPEAT and pulse key_add_down once.
REQ-023 Add key in REPEAT: pulse key_add_down every REPEAT_TICKS ticks while pressed; key_add_long=1 throughout REPEAT, including REL_DB entered from REPEAT, until IDLE or HELD.
REQ-024 Mode key SHALL never repeat; one press yields exactly one key_mode_down pulse.
REQ-025 The two key FSMs SHALL be independent; simultaneous presses may pulse both outputs in the same cycle.
REQ-026 Glitches shorter than one tick between samples SHALL be invisible; all outputs SHALL be registered.
REQ-027 Counters SHALL be sized to clog2 of their maximum value and SHALL saturate or reset, never wrap inside a state.

Reset
REQ-028 reset low SHALL asynchronously clear synchronizers, tick counter, all FSMs to IDLE, all counters to 0, and all outputs to 0.
REQ-029 Reset mid-press SHALL produce no pulse on release from reset, even if the key is still held; a new press is accepted only after a full debounce from IDLE.

Verification (TICK_DIV=4, DEBOUNCE_TICKS=3, LONG_TICKS=8, REPEAT_TICKS=2)
REQ-030 Clean mode press held 40 clocks -> exactly one key_mode_down pulse, 1 clock wide, ~12-16 clocks after the press; key_mode_level=1 from that cycle.
REQ-031 key_add toggling every 3 clocks for 30 clocks, then 0 -> no key_add_down, no key_add_negedge, key_add_level stays 0.
REQ-032 key_add held 80 clocks -> first pulse, then a second pulse 32 clocks later, then pulses every 8 clocks; key_add_long=1 from the second pulse onward.
REQ-033 Release after REQ-032 with a 1-tick bounce to 1 -> no extra down pulse; exactly one key_add_negedge after 3 stable released ticks; key_add_long=0 at IDLE.
REQ-034 Both keys pressed on the same clock -> key_mode_down and key_add_down pulse on the same clock.
REQ-035 reset asserted while key_add is in REPEAT, then released with the key still held -> all outputs 0 immediately; no pulse until the key is released and pressed again.
